// File: rtl/game_uart_pkg.sv
// Shared definitions for the tic-tac-toe status UART: ASCII codes, frame
// layout, FSM encodings and the byte-selection helper.
package game_uart_pkg;

    localparam logic [7:0] ASCII_X   = 8'h58;
    localparam logic [7:0] ASCII_O   = 8'h4F;
    localparam logic [7:0] ASCII_DOT = 8'h2E;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    localparam int         FRAME_BYTES   = 12;
    localparam logic [3:0] LAST_BYTE_IDX = 4'(FRAME_BYTES - 1);

    // Frame sequencer states.
    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_LOAD,
        FRM_SEND
    } frame_state_e;

    // Bit-level transmitter states.
    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_e;

    // Byte idx of a frame: 0..8 are squares 8 down to 0, then status, CR, LF.
    function automatic logic [7:0] frame_byte(
        input logic [3:0] idx,
        input logic [8:0] sq,
        input logic [8:0] pl,
        input logic [7:0] st
    );
        logic [3:0] pos;
        pos = 4'd8 - idx;
        if (idx < 4'd9) begin
            return sq[pos] ? (pl[pos] ? ASCII_X : ASCII_O) : ASCII_DOT;
        end else if (idx == 4'd9) begin
            return st;
        end else if (idx == 4'd10) begin
            return ASCII_CR;
        end
        return ASCII_LF;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter. A byte is accepted when byte_valid_i is high while
// idle or in the last cycle of a stop bit, so consecutive bytes run with no
// idle gap. byte_done_o marks the final cycle of each stop bit.
module uart_byte_tx
    import game_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       byte_done_o
);

    localparam int             TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);

    bit_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (timer_q == T_LAST);
    assign tx_o    = tx_q;

    // Bit timing and serialisation: next state, next bit value, done strobe.
    always_comb begin
        // NOTE: every signal gets a default first, so no latch can be inferred.
        state_d     = state_q;
        timer_d     = timer_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        byte_done_o = 1'b0;

        if (state_q != BIT_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            BIT_IDLE: begin
                if (byte_valid_i) begin
                    shift_d = byte_i;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = BIT_START;
                end
            end
            BIT_START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = BIT_DATA;
                end
            end
            BIT_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = BIT_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            BIT_STOP: begin
                if (bit_end) begin
                    byte_done_o = 1'b1;
                    if (byte_valid_i) begin
                        shift_d = byte_i;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                        state_d = BIT_START;
                    end else begin
                        state_d = BIT_IDLE;
                    end
                end
            end
            default: state_d = BIT_IDLE;
        endcase
    end

    // Bit-level registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: registers use non-blocking assignments so all update together.
        if (!reset_n) begin
            state_q <= BIT_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/game_uart_tx.sv
// Game status transmitter: snapshots the board and status at frame start,
// detects changes against the last snapshot, and sequences the 12 frame
// bytes into the byte transmitter.
module game_uart_tx
    import game_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int FRAME_ON_RESET = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [8:0] occ_square,
    input  logic [8:0] occ_player,
    input  logic [7:0] game_st,
    input  logic       send_req,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    frame_state_e state_q, state_d;
    logic         pending_q, pending_d;
    logic [8:0]   sq_q, sq_d;
    logic [8:0]   pl_q, pl_d;
    logic [7:0]   st_q, st_d;
    logic [3:0]   idx_q, idx_d;
    logic         busy_q, busy_d;
    logic         frame_done_q, frame_done_d;
    logic         change;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_done;

    assign change     = ({occ_square, occ_player, game_st} != {sq_q, pl_q, st_q});
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk         (clk),
        .reset_n     (reset_n),
        .byte_valid_i(byte_valid),
        .byte_i      (byte_data),
        .tx_o        (tx),
        .byte_done_o (byte_done)
    );

    // Frame sequencing: pending tracking, snapshot capture, byte feeding.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | send_req | change;
        sq_d         = sq_q;
        pl_d         = pl_q;
        st_d         = st_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        byte_valid   = 1'b0;
        byte_data    = 8'h00;

        case (state_q)
            FRM_IDLE: begin
                // A request in the same cycle counts, so a send_req alongside
                // frame_done still yields exactly two idle-high cycles.
                if (pending_d) begin
                    state_d = FRM_LOAD;
                end
            end
            FRM_LOAD: begin
                sq_d       = occ_square;
                pl_d       = occ_player;
                st_d       = game_st;
                idx_d      = '0;
                busy_d     = 1'b1;
                // The snapshot taken here absorbs every earlier change.
                pending_d  = send_req;
                byte_valid = 1'b1;
                byte_data  = frame_byte(4'd0, occ_square, occ_player, game_st);
                state_d    = FRM_SEND;
            end
            FRM_SEND: begin
                if (byte_done) begin
                    if (idx_q == LAST_BYTE_IDX) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = FRM_IDLE;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        byte_valid = 1'b1;
                        byte_data  = frame_byte(idx_q + 4'd1, sq_q, pl_q, st_q);
                    end
                end
            end
            default: state_d = FRM_IDLE;
        endcase
    end

    // Frame-level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FRM_IDLE;
            pending_q    <= (FRAME_ON_RESET != 0);
            sq_q         <= '0;
            pl_q         <= '0;
            st_q         <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            sq_q         <= sq_d;
            pl_q         <= pl_d;
            st_q         <= st_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_game_uart_tx.sv
// Directed bench for game_uart_tx with CLKS_PER_BIT=4: decodes frames off
// the serial line and compares them with hand-written byte tables.
module tb_game_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       reset_n;
    logic [8:0] occ_square;
    logic [8:0] occ_player;
    logic [7:0] game_st;
    logic       send_req;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int         n_assert;
    int         n_fail;
    logic [7:0] exp_b [12];

    game_uart_tx #(
        .CLKS_PER_BIT  (CPB),
        .FRAME_ON_RESET(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .occ_square(occ_square),
        .occ_player(occ_player),
        .game_st   (game_st),
        .send_req  (send_req),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    // Polls negedges for the first start bit; latency counts negedges waited.
    task automatic wait_start(input string tag, input int exp_lat);
        int  w;
        bit  seen;
        w    = 0;
        seen = 1'b0;
        while (!seen && w < 200) begin
            @(negedge clk);
            w++;
            if (tx === 1'b0) seen = 1'b1;
        end
        check({tag, " start seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " start latency"}, 32'(w), 32'(exp_lat));
            check({tag, " busy at start"}, 32'(busy), 32'd1);
        end
    endtask

    // Decodes a full frame against exp_b, then checks the frame_done pulse
    // timing; optionally raises send_req in the frame_done cycle.
    task automatic recv_frame(input string tag, input int exp_lat, input bit req_at_done);
        bit         ok;
        logic [7:0] b;
        ok = 1'b1;
        wait_start(tag, exp_lat);
        if (tx !== 1'b0) return;
        for (int j = 0; j < 12; j++) begin
            b = '0;
            for (int k = 0; k < 10; k++) begin
                repeat ((j == 0 && k == 0) ? 2 : CPB) @(negedge clk);
                if (k == 0) begin
                    if (tx !== 1'b0) ok = 1'b0;
                end else if (k == 9) begin
                    if (tx !== 1'b1) ok = 1'b0;
                end else begin
                    b[k-1] = tx;
                end
            end
            check($sformatf("%s byte %0d", tag, j), 32'(b), 32'(exp_b[j]));
        end
        check({tag, " start/stop framing"}, 32'(ok), 32'd1);
        @(negedge clk);  // 479 cycles after the first start bit
        check({tag, " frame_done early"}, 32'(frame_done), 32'd0);
        check({tag, " busy last stop"}, 32'(busy), 32'd1);
        @(negedge clk);  // 480 cycles after the first start bit
        check({tag, " frame_done pulse"}, 32'(frame_done), 32'd1);
        check({tag, " busy cleared"}, 32'(busy), 32'd0);
        check({tag, " tx idle at done"}, 32'(tx), 32'd1);
        if (req_at_done) send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        check({tag, " frame_done single"}, 32'(frame_done), 32'd0);
    endtask

    task automatic idle_quiet(input string tag, input int n);
        int lows;
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        occ_square = 9'h000;
        occ_player = 9'h000;
        game_st    = 8'h6E;
        send_req   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;

        // Frame sent automatically after reset: empty board, status 'n'.
        exp_b = '{8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E,
                  8'h6E, 8'h0D, 8'h0A};
        recv_frame("reset frame", 2, 1'b0);
        idle_quiet("quiet after reset frame", 20);

        // X in the top-left square triggers a frame.
        occ_square = 9'h100;
        occ_player = 9'h100;
        exp_b = '{8'h58, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E,
                  8'h6E, 8'h0D, 8'h0A};
        recv_frame("x corner", 2, 1'b0);
        idle_quiet("stable inputs no frame", 40);

        // Mixed board; inputs churn and requests arrive mid-frame.
        occ_square = 9'h111;
        occ_player = 9'h101;
        game_st    = 8'h58;
        exp_b = '{8'h58, 8'h2E, 8'h2E, 8'h2E, 8'h4F, 8'h2E, 8'h2E, 8'h2E, 8'h58,
                  8'h58, 8'h0D, 8'h0A};
        fork
            recv_frame("mid-frame churn", 2, 1'b0);
            begin
                repeat (40) @(negedge clk);
                occ_player = 9'h1FF;
                occ_square = 9'h000;
                repeat (50) @(negedge clk);
                pulse_req();
                repeat (50) @(negedge clk);
                occ_square = 9'h0AA;
                repeat (50) @(negedge clk);
                pulse_req();
                repeat (50) @(negedge clk);
                occ_square = 9'h000;
            end
        join

        // Single follow-up with the final inputs; occ_player alone shows dots.
        exp_b = '{8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E,
                  8'h58, 8'h0D, 8'h0A};
        recv_frame("follow-up", 1, 1'b0);
        idle_quiet("exactly one follow-up", 40);

        // Reset in the middle of byte 5 aborts at once.
        game_st = 8'h45;
        wait_start("abort frame", 2);
        repeat (220) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort tx high", 32'(tx), 32'd1);
        check("abort busy low", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Fresh frame from byte 0, with send_req landing on frame_done.
        exp_b = '{8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E,
                  8'h45, 8'h0D, 8'h0A};
        recv_frame("restart", 2, 1'b1);
        recv_frame("req at done", 1, 1'b0);
        idle_quiet("quiet at end", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/game_uart_tx.md
Name: game_uart_tx

Overview:
- Serial status transmitter for the tic-tac-toe game. It sends the board occupancy and the ASCII game-status character to a host terminal over 8N1 UART.
- It sits beside the game core and consumes its occupancy vectors and game-status byte.
- A frame is sent after reset, whenever the board or status changes, and on an explicit request.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is >= 2.
- FRAME_ON_RESET, 1: when 1, one frame is sent automatically after reset deasserts.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- occ_square  in  9  1 = square occupied. Bit 8 is top-left, bit 0 is bottom-right.
- occ_player  in  9  1 = X, 0 = O. Meaningful only where occ_square is 1.
- game_st  in  8  ASCII status character from the game core: 'X', 'O', 'C', 'E' or 'n'.
- send_req  in  1  single-cycle request to send a frame.
- tx  out  1  UART serial line. Idles high.
- busy  out  1  high from the first start bit to the end of the last stop bit.
- frame_done  out  1  one-cycle pulse when the final stop bit of a frame completes.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values: tx=1, busy=0, frame_done=0, all counters 0, snapshot registers 0.
  - pending = FRAME_ON_RESET.
  - FSM = IDLE.
  - Reset asserted mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- Frame format: 12 bytes, in this order.
  - Bytes 0..8: squares 8 down to 0. X = 0x58, O = 0x4F, empty = 0x2E ('.').
  - A square with occ_square=0 is sent as '.' regardless of occ_player.
  - Byte 9: game_st, sent verbatim.
  - Byte 10: 0x0D (CR). Byte 11: 0x0A (LF).
- Byte format: start bit 0, eight data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
  - Bytes are back-to-back, with no idle gap between a stop bit and the next start bit.
  - A full frame lasts exactly 120*CLKS_PER_BIT cycles.
- Change detection:
  - A change means {occ_square, occ_player, game_st} differs from the last-sent snapshot.
  - A change or send_req=1 in any cycle sets pending.
  - pending is cleared when a frame starts.
  - Any number of changes or requests during a frame coalesce into exactly one follow-up frame.
- Snapshot: all inputs are captured at frame start. The transmitted bytes reflect the snapshot only; input changes mid-frame do not corrupt the current frame.
- FSM states and transitions:
  - IDLE: tx=1. If pending, go to LOAD on the next edge.
  - LOAD: capture the snapshot, set byte index to 0, set busy=1, go to START.
    - tx falls on the edge leaving LOAD.
    - Start latency is 2 cycles from the first cycle pending is high in IDLE.
  - START: after CLKS_PER_BIT cycles, go to DATA.
  - DATA: after 8 bits, go to STOP.
  - STOP: after CLKS_PER_BIT cycles:
    - If byte index is 11: pulse frame_done, clear busy, go to IDLE.
    - Otherwise: increment the index and go to START.
- Back-to-back frames: if pending is set at frame end, IDLE lasts 1 cycle, so there are at least 2 cycles of tx=1 before the next start bit.
- Widths:
  - Bit-timer width is clog2(CLKS_PER_BIT); the timer wraps to 0 at CLKS_PER_BIT-1.
  - Byte index is 4 bits and never exceeds 11.
  - Data bit counter is 3 bits.
- Simultaneous events: send_req in the same cycle as frame_done sets pending, so a new frame follows. It is not lost.

Decomposition:
- Shared package game_uart_pkg:
  - ASCII constants: X, O, dot, CR, LF.
  - FSM state encoding.
  - FRAME_BYTES = 12.
- Sub-module uart_byte_tx contains START/DATA/STOP bit timing with a byte-valid/done handshake.
- game_uart_tx keeps the snapshot, change detection, pending flag and byte sequencing.

Test Plan (CLKS_PER_BIT=4):
- Reset release, FRAME_ON_RESET=1, empty board, game_st=0x6E:
  - Required: tx falls 2 cycles later.
  - Decoded bytes: 2E x9, 6E, 0D, 0A.
  - frame_done pulses once, 480 cycles after the first start bit.
- Idle, then set occ_square=0x100 and occ_player=0x100:
  - Required: frame decodes to 58, 2E x8, 6E, 0D, 0A.
  - No further frame is sent while the inputs stay stable.
- During a frame, toggle occ_square 3 times and pulse send_req twice:
  - Required: current frame bytes are unchanged.
  - Exactly one follow-up frame is sent, carrying the final input values.
- occ_square=0x000 with occ_player=0x1FF:
  - Required: all board bytes are 2E.
- Assert reset_n low in the middle of byte 5:
  - Required: tx=1 and busy=0 immediately.
  - After release, a fresh full frame starts from byte 0.
- send_req in the same cycle as frame_done:
  - Required: exactly 2 cycles of tx=1, then a new start bit.
